// File: rtl/rc4_mem_pkg.sv
// rtl/rc4_mem_pkg.sv - shared widths, direction codes and responder states for the S RAM handshake
package rc4_mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    RESPOND = 2'd3
  } resp_state_e;

endpackage

// File: rtl/s_mem_arbiter.sv
// rtl/s_mem_arbiter.sv - fixed-priority grant over pending requests, index 0 wins
module s_mem_arbiter #(
  parameter int N_CLIENTS = 3,
  parameter int IDX_W     = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
  input  logic [N_CLIENTS-1:0] pending,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx
);

  logic [N_CLIENTS-1:0] grant_oh;

  // Isolating the lowest set bit gives a one-hot grant, then encode it.
  always_comb begin
    grant_oh    = pending & (~pending + N_CLIENTS'(1));
    grant_valid = |pending;
    grant_idx   = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (grant_oh[i]) begin
        grant_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/s_mem_responder.sv
// rtl/s_mem_responder.sv - queues client start pulses, serves them on the S RAM, returns finish pulses
module s_mem_responder
  import rc4_mem_pkg::*;
#(
  parameter int N_CLIENTS  = 3,
  parameter int RD_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_CLIENTS-1:0]             start_readWrite_op,
  input  logic [N_CLIENTS-1:0][ADDR_W-1:0] client_address,
  input  logic [N_CLIENTS-1:0][DATA_W-1:0] client_data,
  input  logic [N_CLIENTS-1:0]             client_readWrite,
  output logic [N_CLIENTS-1:0]             finish_readWrite_op,
  output logic [DATA_W-1:0]                read_data,
  output logic [ADDR_W-1:0]                mem_address,
  output logic [DATA_W-1:0]                mem_data,
  output logic                             mem_wren,
  input  logic [DATA_W-1:0]                mem_q,
  output logic                             busy
);

  localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int CNT_W = 2;

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_ISSUE   = ISSUE;
  localparam logic [1:0] ST_RD_WAIT = RD_WAIT;
  localparam logic [1:0] ST_RESPOND = RESPOND;

  logic [1:0]                       state;
  logic [N_CLIENTS-1:0]             pending;
  logic [N_CLIENTS-1:0][ADDR_W-1:0] req_addr;
  logic [N_CLIENTS-1:0][DATA_W-1:0] req_data;
  logic [N_CLIENTS-1:0]             req_rw;
  logic [IDX_W-1:0]                 gnt;
  logic                             svc_rw;
  logic [CNT_W-1:0]                 cnt;

  logic                             grant_valid;
  logic [IDX_W-1:0]                 grant_idx;
  logic [N_CLIENTS-1:0]             retire;
  logic [N_CLIENTS-1:0]             capture;

  s_mem_arbiter #(
    .N_CLIENTS (N_CLIENTS),
    .IDX_W     (IDX_W)
  ) u_arbiter (
    .pending     (pending),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // A client being retired this edge may re-request on the same edge.
  always_comb begin
    retire = '0;
    if (state == ST_RESPOND) begin
      retire = N_CLIENTS'(1) << gnt;
    end
    capture = start_readWrite_op & (~pending | retire);
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= ST_IDLE;
      pending             <= '0;
      req_addr            <= '0;
      req_data            <= '0;
      req_rw              <= '0;
      gnt                 <= '0;
      svc_rw              <= RW_READ;
      cnt                 <= '0;
      finish_readWrite_op <= '0;
      read_data           <= '0;
      mem_address         <= '0;
      mem_data            <= '0;
      mem_wren            <= 1'b0;
    end else begin
      pending <= (pending & ~retire) | capture;
      for (int i = 0; i < N_CLIENTS; i++) begin
        if (capture[i]) begin
          req_addr[i] <= client_address[i];
          req_data[i] <= client_data[i];
          req_rw[i]   <= client_readWrite[i];
        end
      end

      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            gnt         <= grant_idx;
            svc_rw      <= req_rw[grant_idx];
            mem_address <= req_addr[grant_idx];
            mem_data    <= req_data[grant_idx];
            mem_wren    <= (req_rw[grant_idx] == RW_WRITE);
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_wren <= 1'b0;
          if (svc_rw == RW_READ) begin
            cnt   <= CNT_W'(RD_LATENCY - 1);
            state <= ST_RD_WAIT;
          end else begin
            finish_readWrite_op[gnt] <= 1'b1;
            state                    <= ST_RESPOND;
          end
        end
        ST_RD_WAIT: begin
          if (cnt == '0) begin
            read_data                <= mem_q;
            finish_readWrite_op[gnt] <= 1'b1;
            state                    <= ST_RESPOND;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          finish_readWrite_op <= '0;
          state               <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s_mem_responder.sv
// tb/tb_s_mem_responder.sv - randomized and directed check of s_mem_responder at read latency 1 and 3
module tb_s_mem_responder;

  logic            clk;
  logic            reset;
  logic [2:0]      start;
  logic [2:0][7:0] caddr;
  logic [2:0][7:0] cdata;
  logic [2:0]      crw;
  int              total = 0;
  int              bad   = 0;
  bit              armed = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Lane 0 runs RD_LATENCY=1, lane 1 runs RD_LATENCY=3; both see identical stimulus.
  for (genvar ln = 0; ln < 2; ln++) begin : lane
    localparam int L = (ln == 0) ? 1 : 3;

    logic [2:0] fin;
    logic [7:0] rd, maddr, mdata, mq;
    logic       wren, busy;
    logic [7:0] ram  [256];
    logic [7:0] pipe [L];

    s_mem_responder #(
      .N_CLIENTS  (3),
      .RD_LATENCY (L)
    ) u_dut (
      .clk                 (clk),
      .reset               (reset),
      .start_readWrite_op  (start),
      .client_address      (caddr),
      .client_data         (cdata),
      .client_readWrite    (crw),
      .finish_readWrite_op (fin),
      .read_data           (rd),
      .mem_address         (maddr),
      .mem_data            (mdata),
      .mem_wren            (wren),
      .mem_q               (mq),
      .busy                (busy)
    );

    // RAM: address sampled each edge, data appears L edges later.
    assign mq = pipe[L-1];
    always @(posedge clk) begin
      if (wren) ram[maddr] <= mdata;
      pipe[0] <= ram[maddr];
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end

    logic [7:0] gold [256];
    logic [2:0] pend = '0;
    logic [2:0] retire;
    logic [7:0] m_addr [3];
    logic [7:0] m_data [3];
    logic       m_rw   [3];
    bit         act = 1'b0;
    int         age = 0, len = 0, cl = 0;
    logic [2:0] e_fin  = '0;
    logic [7:0] e_rd   = '0, e_addr = '0, e_data = '0;
    logic       e_wren = 1'b0, e_busy = 1'b0;

    initial begin
      for (int k = 0; k < 256; k++) begin
        gold[k] = 8'(k) ^ 8'h5a;
        ram[k] <= 8'(k) ^ 8'h5a;
      end
    end

    // Service model: a granted write occupies 2 edges after grant, a read 2+L;
    // finish is high during the last cycle of that window.
    always @(posedge clk) begin
      if (act && age == 0 && m_rw[cl]) gold[m_addr[cl]] = m_data[cl];
      if (reset) begin
        act = 1'b0; age = 0; pend = '0;
        e_fin = '0; e_rd = '0; e_addr = '0; e_data = '0; e_wren = 1'b0; e_busy = 1'b0;
      end else begin
        retire = '0;
        e_fin  = '0;
        e_wren = 1'b0;
        if (act) begin
          age++;
          if (age == len) begin
            act = 1'b0;
            retire[cl] = 1'b1;
          end
        end else if (pend != 3'b000) begin
          for (int i = 2; i >= 0; i--) if (pend[i]) cl = i;
          act    = 1'b1;
          age    = 0;
          len    = m_rw[cl] ? 2 : 2 + L;
          e_addr = m_addr[cl];
          e_data = m_data[cl];
          e_wren = m_rw[cl];
        end
        if (act && age == len - 1) begin
          e_fin[cl] = 1'b1;
          if (!m_rw[cl]) e_rd = gold[m_addr[cl]];
        end
        e_busy = act;
        for (int i = 0; i < 3; i++) begin
          if (retire[i]) pend[i] = 1'b0;
          if (start[i] && !pend[i]) begin
            pend[i]   = 1'b1;
            m_addr[i] = caddr[i];
            m_data[i] = cdata[i];
            m_rw[i]   = crw[i];
          end
        end
      end
    end

    always @(negedge clk) begin
      if (armed) begin
        chk($sformatf("L%0d_finish", L), fin, e_fin);
        chk($sformatf("L%0d_read_data", L), rd, e_rd);
        chk($sformatf("L%0d_mem_address", L), maddr, e_addr);
        chk($sformatf("L%0d_mem_data", L), mdata, e_data);
        chk($sformatf("L%0d_mem_wren", L), wren, e_wren);
        chk($sformatf("L%0d_busy", L), busy, e_busy);
      end
    end
  end

  task automatic issue(int c, int a, int d, bit w);
    start[c] = 1'b1;
    caddr[c] = 8'(a);
    cdata[c] = 8'(d);
    crw[c]   = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    start = '0;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  int t0, t2, c0, c1, nf;
  logic [7:0] rd0, rd2;

  initial begin
    reset = 1'b1;
    start = '0;
    caddr = '0;
    cdata = '0;
    crw   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    armed = 1'b1;
    chk("rst_finish", lane[0].fin, 0);
    chk("rst_read_data", lane[0].rd, 0);
    chk("rst_mem_address", lane[0].maddr, 0);
    chk("rst_mem_wren", lane[0].wren, 0);
    chk("rst_busy", lane[0].busy, 0);

    // single write
    issue(0, 8'h05, 8'hA5, 1'b1);
    tick();
    chk("wr_busy_e0", lane[0].busy, 0);
    tick();
    chk("wr_wren_e1", lane[0].wren, 1);
    chk("wr_addr_e1", lane[0].maddr, 8'h05);
    chk("wr_data_e1", lane[0].mdata, 8'hA5);
    chk("wr_fin_e1", lane[0].fin, 0);
    tick();
    chk("wr_wren_e2", lane[0].wren, 0);
    chk("wr_fin_e2", lane[0].fin, 3'b001);
    tick();
    chk("wr_fin_e3", lane[0].fin, 0);
    chk("wr_busy_e3", lane[0].busy, 0);
    idle(8);

    // write then read
    issue(0, 8'h10, 8'h3C, 1'b1);
    idle(8);
    issue(1, 8'h10, 8'h00, 1'b0);
    tick();
    tick();
    tick();
    chk("rd_fin_e2", lane[0].fin, 0);
    tick();
    chk("rd_fin_e3", lane[0].fin, 3'b010);
    chk("rd_data_e3", lane[0].rd, 8'h3C);
    tick();
    chk("rd_fin_e4", lane[0].fin, 0);
    chk("rd_data_hold", lane[0].rd, 8'h3C);
    idle(8);

    // contention: client 2 read and client 0 write of the same address
    issue(2, 8'h00, 8'h00, 1'b0);
    issue(0, 8'h00, 8'h77, 1'b1);
    tick();
    t0 = -1; t2 = -1; rd2 = '0;
    for (int k = 0; k < 20; k++) begin
      if (lane[0].fin[0] && t0 < 0) t0 = k;
      if (lane[0].fin[2] && t2 < 0) begin t2 = k; rd2 = lane[0].rd; end
      tick();
    end
    chk("cont_order", int'(t0 >= 0 && t2 > t0), 1);
    chk("cont_gap", t2 - t0 - 1, 3);
    chk("cont_rdata", rd2, 8'h77);
    idle(4);

    // client 1 queued while client 0 read waits on the RAM
    issue(0, 8'h20, 8'h00, 1'b0);
    tick();
    tick();
    tick();
    issue(1, 8'h21, 8'h00, 1'b0);
    c0 = 0; c1 = 0; rd0 = '0; rd2 = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (lane[0].fin[0]) begin c0++; rd0 = lane[0].rd; end
      if (lane[0].fin[1]) begin c1++; rd2 = lane[0].rd; end
    end
    chk("queue_fin0_count", c0, 1);
    chk("queue_fin1_count", c1, 1);
    chk("queue_rd0", rd0, 8'h7a);
    chk("queue_rd1", rd2, 8'h7b);

    // back-to-back writes from client 0, second start on the RESPOND edge
    issue(0, 8'h30, 8'h11, 1'b1);
    tick();
    tick();
    tick();
    chk("b2b_fin_first", lane[0].fin, 3'b001);
    issue(0, 8'h31, 8'h22, 1'b1);
    tick();
    chk("b2b_gap_busy", lane[0].busy, 0);
    tick();
    chk("b2b_wren", lane[0].wren, 1);
    chk("b2b_addr", lane[0].maddr, 8'h31);
    chk("b2b_data", lane[0].mdata, 8'h22);
    tick();
    chk("b2b_fin_second", lane[0].fin, 3'b001);
    idle(8);

    // reset while the latency-3 lane is in RD_WAIT
    issue(0, 8'h10, 8'h00, 1'b0);
    tick();
    tick();
    tick();
    tick();
    chk("rst_mid_busy_before", lane[1].busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_finish", lane[1].fin, 0);
    chk("rstmid_read_data", lane[1].rd, 0);
    chk("rstmid_mem_address", lane[1].maddr, 0);
    chk("rstmid_mem_data", lane[1].mdata, 0);
    chk("rstmid_mem_wren", lane[1].wren, 0);
    chk("rstmid_busy", lane[1].busy, 0);
    nf = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (lane[1].fin != 3'b000) nf++;
    end
    chk("rstmid_no_finish", nf, 0);
    issue(2, 8'h40, 8'h99, 1'b1);
    tick();
    tick();
    chk("rstmid_wr_wren", lane[1].wren, 1);
    chk("rstmid_wr_addr", lane[1].maddr, 8'h40);
    tick();
    chk("rstmid_wr_fin", lane[1].fin, 3'b100);
    idle(8);

    // randomized traffic, including starts while pending and occasional resets
    for (int n = 0; n < 3000; n++) begin
      tick();
      reset = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < 3; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          issue(c, $urandom_range(0, 7), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
        end
      end
    end
    tick();
    reset = 1'b0;
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
